// File: rtl/gamma_cycle_sequencer_if.sv
// Request/result handshake bundle between binary-coded logic and the gamma cycle sequencer.
interface gamma_cycle_sequencer_if #(
  parameter int TIME_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [TIME_W-1:0] req_ta;
  logic [TIME_W-1:0] req_tb;
  logic              res_valid;
  logic              res_ready;
  logic [TIME_W-1:0] res_time;

  modport master (
    output req_valid, req_ta, req_tb, res_ready,
    input  req_ready, res_valid, res_time
  );

  modport slave (
    input  req_valid, req_ta, req_tb, res_ready,
    output req_ready, res_valid, res_time
  );
endinterface

// File: rtl/gamma_cycle_sequencer.sv
// Runs one race-logic primitive through a gamma cycle per request: clear, drive a/b at their
// spike times, record the first output event time, return it over a valid/ready handshake.
module gamma_cycle_sequencer #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int MODE              = 1,
  parameter int CLEAR_CYCLES      = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  gamma_cycle_sequencer_if.slave        bus,
  output logic                          o_prim_rst,
  output logic                          o_prim_a,
  output logic                          o_prim_b,
  input  logic                          i_prim_q
);
  localparam int   TIME_W   = $clog2(GAMMA_CYCLE_WIDTH + 1);
  localparam int   CNT_MAX  = (GAMMA_CYCLE_WIDTH > CLEAR_CYCLES + 1) ? GAMMA_CYCLE_WIDTH
                                                                       : CLEAR_CYCLES + 1;
  localparam int   CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic IDLE_LVL = (MODE == 2) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic [TIME_W-1:0] r_ta, r_tb, r_time;
  logic              r_found, r_prim_rst, r_prim_a, r_prim_b, r_res_valid;
  logic              w_run_nx, w_event, w_a_nx, w_b_nx, w_accept;

  // Drive level for operand time T in RUN cycle t; T beyond the window never fires.
  function automatic logic drive(input logic [TIME_W-1:0] T, input logic [CNT_W-1:0] t);
    logic [31:0] w_t, w_T;
    w_t = 32'(t);
    w_T = 32'(T);
    case (MODE)
      0:       return (w_t >= w_T) && (w_t < w_T + 32'(PULSE_WIDTH));
      2:       return !(w_t >= w_T);
      default: return (w_t >= w_T);
    endcase
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;
  assign w_event  = (MODE == 2) ? ~i_prim_q : i_prim_q;

  // CLEAR spans the operand-capture cycle plus CLEAR_CYCLES of primitive clear, so the
  // registered drive for RUN cycle t lines up with the counter value t.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      S_IDLE: if (bus.req_valid) begin
        w_state_nx = S_CLEAR;
        w_cnt_nx   = '0;
      end
      S_CLEAR: if (r_cnt == CNT_W'(CLEAR_CYCLES)) begin
        w_state_nx = S_RUN;
        w_cnt_nx   = '0;
      end else begin
        w_cnt_nx = r_cnt + 1'b1;
      end
      S_RUN: if (r_cnt == CNT_W'(GAMMA_CYCLE_WIDTH - 1)) begin
        w_state_nx = S_DONE;
      end else begin
        w_cnt_nx = r_cnt + 1'b1;
      end
      S_DONE: if (bus.res_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    w_run_nx = (w_state_nx == S_RUN);
    w_a_nx   = w_run_nx ? drive(r_ta, w_cnt_nx) : IDLE_LVL;
    w_b_nx   = w_run_nx ? drive(r_tb, w_cnt_nx) : IDLE_LVL;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ta        <= '0;
      r_tb        <= '0;
      r_found     <= 1'b0;
      r_time      <= '0;
      r_prim_rst  <= 1'b1;
      r_prim_a    <= IDLE_LVL;
      r_prim_b    <= IDLE_LVL;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_prim_rst  <= (w_state_nx == S_IDLE) || (w_state_nx == S_CLEAR);
      r_prim_a    <= w_a_nx;
      r_prim_b    <= w_b_nx;
      r_res_valid <= (w_state_nx == S_DONE);
      if (w_accept) begin
        r_ta    <= bus.req_ta;
        r_tb    <= bus.req_tb;
        r_found <= 1'b0;
      end
      // First event is sticky; no event by the last cycle saturates to the window width.
      if (r_state == S_RUN && !r_found) begin
        if (w_event) begin
          r_found <= 1'b1;
          r_time  <= TIME_W'(r_cnt);
        end else if (r_cnt == CNT_W'(GAMMA_CYCLE_WIDTH - 1)) begin
          r_time  <= TIME_W'(GAMMA_CYCLE_WIDTH);
        end
      end
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.res_valid = r_res_valid;
  assign bus.res_time  = r_time;
  assign o_prim_rst    = r_prim_rst;
  assign o_prim_a      = r_prim_a;
  assign o_prim_b      = r_prim_b;
endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
// Three sequencers (MODE 0/1/2) share one stimulus stream; a cycle-count model predicts every output.
module tb_gamma_cycle_sequencer;
  localparam int G  = 16;
  localparam int PW = 8;
  localparam int C  = 2;
  localparam int TW = 5;

  logic          clk, rst;
  logic          req_valid, res_ready;
  logic [TW-1:0] ta, tb;
  int            sel;
  int            checks = 0, errors = 0;
  bit            started = 0;

  gamma_cycle_sequencer_if #(.TIME_W(TW)) bus0 ();
  gamma_cycle_sequencer_if #(.TIME_W(TW)) bus1 ();
  gamma_cycle_sequencer_if #(.TIME_W(TW)) bus2 ();

  logic          d_rdy[3], d_vld[3], d_prst[3], d_pa[3], d_pb[3], d_q[3];
  logic [TW-1:0] d_time[3];

  function automatic bit qf(int s, bit a, bit b);
    case (s)
      0: return a;
      1: return b;
      2: return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic bit drv(int mode, int T, int t);
    case (mode)
      0: return (t >= T) && (t < T + PW);
      2: return !(t >= T);
      default: return t >= T;
    endcase
  endfunction

  function automatic int exp_time(int mode, int a_t, int b_t, int s);
    for (int t = 0; t < G; t++) begin
      bit q;
      q = qf(s, drv(mode, a_t, t), drv(mode, b_t, t));
      if ((mode == 2) ? !q : q) return t;
    end
    return G;
  endfunction

  assign {bus0.req_valid, bus1.req_valid, bus2.req_valid} = {3{req_valid}};
  assign {bus0.res_ready, bus1.res_ready, bus2.res_ready} = {3{res_ready}};
  assign bus0.req_ta = ta;  assign bus1.req_ta = ta;  assign bus2.req_ta = ta;
  assign bus0.req_tb = tb;  assign bus1.req_tb = tb;  assign bus2.req_tb = tb;
  assign d_rdy[0] = bus0.req_ready;  assign d_rdy[1] = bus1.req_ready;  assign d_rdy[2] = bus2.req_ready;
  assign d_vld[0] = bus0.res_valid;  assign d_vld[1] = bus1.res_valid;  assign d_vld[2] = bus2.res_valid;
  assign d_time[0] = bus0.res_time;  assign d_time[1] = bus1.res_time;  assign d_time[2] = bus2.res_time;
  assign d_q[0] = qf(sel, d_pa[0], d_pb[0]);
  assign d_q[1] = qf(sel, d_pa[1], d_pb[1]);
  assign d_q[2] = qf(sel, d_pa[2], d_pb[2]);

  gamma_cycle_sequencer #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .MODE(0), .CLEAR_CYCLES(C)) u0 (
    .i_clk(clk), .i_rst(rst), .bus(bus0), .o_prim_rst(d_prst[0]), .o_prim_a(d_pa[0]),
    .o_prim_b(d_pb[0]), .i_prim_q(d_q[0]));
  gamma_cycle_sequencer #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .MODE(1), .CLEAR_CYCLES(C)) u1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1), .o_prim_rst(d_prst[1]), .o_prim_a(d_pa[1]),
    .o_prim_b(d_pb[1]), .i_prim_q(d_q[1]));
  gamma_cycle_sequencer #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .MODE(2), .CLEAR_CYCLES(C)) u2 (
    .i_clk(clk), .i_rst(rst), .bus(bus2), .o_prim_rst(d_prst[2]), .o_prim_a(d_pa[2]),
    .o_prim_b(d_pb[2]), .i_prim_q(d_q[2]));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", n, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 busy (k = cycles since accepting edge), 2 result pending.
  int m_phase = 0, m_k = 0, m_ta = 0, m_tb = 0;
  int m_exp[3];

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_phase = 0;
      m_k     = 0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          m_ta = int'(ta);
          m_tb = int'(tb);
          for (int m = 0; m < 3; m++) m_exp[m] = exp_time(m, m_ta, m_tb, sel);
          m_phase = 1;
          m_k     = 1;
        end
        1: begin
          m_k++;
          if (m_k == C + G + 2) m_phase = 2;
        end
        default: if (res_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int m = 0; m < 3; m++) begin
        bit idle_lvl, e_prst, e_a, e_b;
        idle_lvl = (m == 2);
        e_prst   = (m_phase == 0) || (m_phase == 1 && m_k <= C + 1);
        e_a      = idle_lvl;
        e_b      = idle_lvl;
        if (m_phase == 1 && m_k >= C + 2) begin
          e_a = drv(m, m_ta, m_k - C - 2);
          e_b = drv(m, m_tb, m_k - C - 2);
        end
        chk($sformatf("req_ready[m%0d]", m), 32'(d_rdy[m]), 32'(m_phase == 0));
        chk($sformatf("res_valid[m%0d]", m), 32'(d_vld[m]), 32'(m_phase == 2));
        chk($sformatf("prim_rst[m%0d]", m), 32'(d_prst[m]), 32'(e_prst));
        chk($sformatf("prim_a[m%0d]", m), 32'(d_pa[m]), 32'(e_a));
        chk($sformatf("prim_b[m%0d]", m), 32'(d_pb[m]), 32'(e_b));
        if (m_phase == 2) chk($sformatf("res_time[m%0d]", m), 32'(d_time[m]), 32'(m_exp[m]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed request; e[m] < 0 skips the literal result check for that mode.
  task automatic run_req(input int a_t, input int b_t, input int s, input int hold,
                         input int e0, input int e1, input int e2);
    int lat;
    int e[3];
    logic [TW-1:0] held;
    e = '{e0, e1, e2};
    chk("dir_ready_before", 32'(d_rdy[1]), 1);
    req_valid = 1; ta = TW'(a_t); tb = TW'(b_t); sel = s;
    step();
    req_valid = 0;
    lat = 0;
    while (d_vld[1] !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    chk("dir_latency", 32'(lat), 19);
    for (int m = 0; m < 3; m++)
      if (e[m] >= 0) chk($sformatf("dir_time[m%0d]", m), 32'(d_time[m]), 32'(e[m]));
    held = d_time[1];
    res_ready = 0;
    req_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 32'(d_vld[1]), 1);
      chk("hold_time", 32'(d_time[1]), 32'(held));
      chk("hold_ready", 32'(d_rdy[1]), 0);
    end
    req_valid = 0;
    res_ready = 1;
    step();
    res_ready = 0;
    chk("after_res_ready", 32'(d_rdy[1]), 1);
    chk("after_res_valid", 32'(d_vld[1]), 0);
  endtask

  initial begin
    rst = 1; req_valid = 0; res_ready = 0; ta = '0; tb = '0; sel = 0;
    step();
    step();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("rst_time[m%0d]", m), 32'(d_time[m]), 0);
      chk($sformatf("rst_prim_rst[m%0d]", m), 32'(d_prst[m]), 1);
      chk($sformatf("rst_prim_a[m%0d]", m), 32'(d_pa[m]), (m == 2) ? 1 : 0);
    end
    rst = 0;
    step();

    run_req(5, 9, 0, 0, 5, 5, 5);
    run_req(20, 20, 0, 0, 16, 16, 16);
    run_req(12, 3, 0, 0, 12, 12, 12);
    run_req(0, 7, 0, 0, 0, 0, 0);
    run_req(7, 2, 2, 10, 7, 7, 2);

    // Reset in the middle of RUN (t=6), then a normal request.
    req_valid = 1; ta = 5'd4; tb = 5'd10; sel = 0;
    step();
    req_valid = 0;
    repeat (9) step();
    chk("pre_rst_in_run", 32'(d_prst[1]), 0);
    rst = 1;
    step();
    rst = 0;
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("midrst_ready[m%0d]", m), 32'(d_rdy[m]), 1);
      chk($sformatf("midrst_valid[m%0d]", m), 32'(d_vld[m]), 0);
      chk($sformatf("midrst_prim_rst[m%0d]", m), 32'(d_prst[m]), 1);
      chk($sformatf("midrst_prim_b[m%0d]", m), 32'(d_pb[m]), (m == 2) ? 1 : 0);
    end
    run_req(3, 1, 3, 0, 1, 1, 3);

    // Randomized traffic; the negedge model compare does the checking.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst       = ($urandom_range(0, 599) == 0);
      res_ready = ($urandom_range(0, 2) != 0);
      req_valid = ($urandom_range(0, 1) == 1);
      ta = TW'($urandom_range(0, 31));
      tb = TW'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) ta = TW'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) tb = TW'($urandom_range(0, 15));
      if (m_phase == 0) sel = int'($urandom_range(0, 3));
      step();
    end
    rst = 0; req_valid = 0; res_ready = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
